load_store_unit: RTL and testbench

MEM-stage load/store unit of the pipelined RV32I core. It turns the MEM-stage memory controls into a req/gnt/rvalid data-memory transaction, with byte/half/word lane steering and load sign/zero extension. It produces readDataM, which the MEM/WB pipeline register captures, and it holds the pipeline via lsuStall until the access completes.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/load_extend.sv | 42 ++++
 rtl/load_store_unit.sv | 176 +++++++++++++++++
 tb/tb_load_store_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the MEM-stage load/store unit.
//   - RV32I load/store funct3 encodings
//   - FSM state type and access-size type
//   - helpers for access size decode and byte-enable generation
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP, HOLD} lsu_state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

  // Store encodings 100/101 do not exist, so they fall back to word like any
  // other unused funct3 value.
  function automatic lsu_size_t access_size(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_B:    return SZ_B;
      F3_H:    return SZ_H;
      F3_BU:   return is_store ? SZ_W : SZ_B;
      F3_HU:   return is_store ? SZ_W : SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  // lo is expected to be naturally aligned for the size already.
  function automatic logic [3:0] byte_enable(input lsu_size_t size, input logic [1:0] lo);
    case (size)
      SZ_B:    return 4'b0001 << lo;
      SZ_H:    return 4'b0011 << {lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: combinational load data extraction.
//   word   - raw 32-bit read word from the data bus
//   lo     - byte offset of the access within the word
//   funct3 - RV32I load encoding (unused values pass the word through)
//   data   - lane-selected, sign/zero-extended result
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output of a combinational block gets a value on every path;
  // a missing default here would infer a latch.
  always_comb begin
    byte_sel = word[7:0];
    case (lo)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
  end

  assign half_sel = lo[1] ? word[31:16] : word[15:0];

  always_comb begin
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'b0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'b0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store unit of the RV32I pipeline.
// Converts MEM-stage load/store controls into a req/gnt/rvalid data bus
// transaction with lane steering and load extension, and stalls the pipeline
// (lsuStall) until the access completes.
//   Pipeline side: memReadM, memWriteM, funct3M, addrM, writeDataM, stallM in;
//                  readDataM, lsuStall, misalignM out.
//   Bus side:      dReq, dWe, dBe, dAddr, dWdata out; dGnt, dRvalid, dRdata in.
// Build option: LSU_MISALIGN_CHECK_EN - flag and suppress misaligned accesses
// instead of forcing them to natural alignment.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memReadM,
  input  logic                  memWriteM,
  input  logic [2:0]            funct3M,
  input  logic [31:0]           addrM,
  input  logic [31:0]           writeDataM,
  input  logic                  stallM,
  output logic [31:0]           readDataM,
  output logic                  lsuStall,
  output logic                  misalignM,
  output logic                  dReq,
  output logic                  dWe,
  output logic [3:0]            dBe,
  output logic [ADDR_WIDTH-1:0] dAddr,
  output logic [31:0]           dWdata,
  input  logic                  dGnt,
  input  logic                  dRvalid,
  input  logic [31:0]           dRdata
);

  lsu_state_t state, state_nxt;

  logic                  access;
  logic                  issue;
  lsu_size_t             size;
  logic [1:0]            addr_lo;
  logic [ADDR_WIDTH-1:0] addr_cmb;
  logic [3:0]            be_cmb;
  logic [31:0]           wdata_cmb;

  // Request captured at issue so the bus stays stable while waiting for grant.
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            be_q;
  logic [31:0]           wdata_q;
  logic                  we_q;
  logic [1:0]            addrLat;
  logic [2:0]            f3Lat;
  logic [31:0]           holdData;
  logic [31:0]           ext_data;

  assign access = memReadM | memWriteM;
  assign size   = access_size(funct3M, memWriteM);

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalignM = access & (((size == SZ_H) & addrM[0]) |
                               ((size == SZ_W) & (addrM[1:0] != 2'b00)));
  assign addr_lo   = addrM[1:0];
`else
  assign misalignM = 1'b0;
  // Misaligned offsets are rounded down to the natural boundary.
  always_comb begin
    case (size)
      SZ_B:    addr_lo = addrM[1:0];
      SZ_H:    addr_lo = {addrM[1], 1'b0};
      default: addr_lo = 2'b00;
    endcase
  end
`endif

  assign issue     = access & ~misalignM;
  assign addr_cmb  = {addrM[ADDR_WIDTH-1:2], 2'b00};
  assign be_cmb    = byte_enable(size, addr_lo);
  assign wdata_cmb = (size == SZ_B) ? {4{writeDataM[7:0]}}  :
                     (size == SZ_H) ? {2{writeDataM[15:0]}} : writeDataM;

  load_extend u_load_extend (
    .word   (dRdata),
    .lo     (addrLat),
    .funct3 (f3Lat),
    .data   (ext_data)
  );

  always_comb begin
    state_nxt = state;
    dReq      = 1'b0;
    dWe       = 1'b0;
    dBe       = 4'b0;
    dAddr     = '0;
    dWdata    = '0;
    lsuStall  = 1'b0;
    readDataM = '0;
    case (state)
      IDLE: begin
        if (issue) begin
          dReq   = 1'b1;
          dWe    = memWriteM;
          dBe    = be_cmb;
          dAddr  = addr_cmb;
          dWdata = wdata_cmb;
          if (!dGnt) begin
            lsuStall  = 1'b1;
            state_nxt = WAIT_GNT;
          end else if (memWriteM) begin
            // Store done; park in HOLD if MEM is frozen so it is not re-issued.
            state_nxt = stallM ? HOLD : IDLE;
          end else begin
            lsuStall  = 1'b1;
            state_nxt = WAIT_RSP;
          end
        end
      end
      WAIT_GNT: begin
        dReq   = 1'b1;
        dWe    = we_q;
        dBe    = be_q;
        dAddr  = addr_q;
        dWdata = wdata_q;
        if (!dGnt) begin
          lsuStall = 1'b1;
        end else if (we_q) begin
          state_nxt = stallM ? HOLD : IDLE;
        end else begin
          lsuStall  = 1'b1;
          state_nxt = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (dRvalid) begin
          readDataM = ext_data;
          state_nxt = stallM ? HOLD : IDLE;
        end else begin
          lsuStall = 1'b1;
        end
      end
      HOLD: begin
        readDataM = holdData;
        if (!stallM) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      addrLat  <= '0;
      f3Lat    <= '0;
      holdData <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && issue) begin
        addr_q  <= addr_cmb;
        be_q    <= be_cmb;
        wdata_q <= wdata_cmb;
        we_q    <= memWriteM;
        addrLat <= addr_lo;
        f3Lat   <= funct3M;
      end
      // Only a load entering HOLD has data to keep; a store holds zero.
      if (state != HOLD && state_nxt == HOLD)
        holdData <= (state == WAIT_RSP) ? ext_data : '0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk;
  logic        rst;
  logic        memReadM, memWriteM, stallM;
  logic [2:0]  funct3M;
  logic [31:0] addrM, writeDataM;
  logic [31:0] readDataM;
  logic        lsuStall, misalignM;
  logic        dReq, dWe;
  logic [3:0]  dBe;
  logic [31:0] dAddr, dWdata;
  logic        dGnt, dRvalid;
  logic [31:0] dRdata;

  int n_total = 0;
  int n_bad   = 0;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .memReadM   (memReadM),
    .memWriteM  (memWriteM),
    .funct3M    (funct3M),
    .addrM      (addrM),
    .writeDataM (writeDataM),
    .stallM     (stallM),
    .readDataM  (readDataM),
    .lsuStall   (lsuStall),
    .misalignM  (misalignM),
    .dReq       (dReq),
    .dWe        (dWe),
    .dBe        (dBe),
    .dAddr      (dAddr),
    .dWdata     (dWdata),
    .dGnt       (dGnt),
    .dRvalid    (dRvalid),
    .dRdata     (dRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks run 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    memReadM = 0; memWriteM = 0; funct3M = 0; addrM = 0; writeDataM = 0;
    stallM = 0; dGnt = 0; dRvalid = 0; dRdata = 0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".dReq"}, 32'(dReq), 0);
    check({tag, ".dBe"}, 32'(dBe), 0);
    check({tag, ".dAddr"}, dAddr, 0);
    check({tag, ".dWdata"}, dWdata, 0);
    check({tag, ".rd"}, readDataM, 0);
    check({tag, ".stall"}, 32'(lsuStall), 0);
    check({tag, ".mis"}, 32'(misalignM), 0);
  endtask

  // Zero-wait load: grant in the request cycle, rvalid one cycle later.
  task automatic load0(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [3:0] exp_be, input logic [31:0] exp_addr,
                       input logic [31:0] rdata, input logic [31:0] exp_rd);
    memReadM = 1; funct3M = f3; addrM = a; dGnt = 1;
    #1;
    check({tag, ".dReq"}, 32'(dReq), 1);
    check({tag, ".dWe"}, 32'(dWe), 0);
    check({tag, ".dBe"}, 32'(dBe), 32'(exp_be));
    check({tag, ".dAddr"}, dAddr, exp_addr);
    check({tag, ".stall0"}, 32'(lsuStall), 1);
    tick();
    dGnt = 0; dRvalid = 1; dRdata = rdata;
    #1;
    check({tag, ".dReq1"}, 32'(dReq), 0);
    check({tag, ".stall1"}, 32'(lsuStall), 0);
    check({tag, ".rd"}, readDataM, exp_rd);
    tick();
    idle_inputs();
    #1;
    check({tag, ".rd_after"}, readDataM, 0);
  endtask

  // Zero-wait store: grant in the request cycle, no stall.
  task automatic store0(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] exp_be,
                        input logic [31:0] exp_addr, input logic [31:0] exp_wd);
    memWriteM = 1; funct3M = f3; addrM = a; writeDataM = wd; dGnt = 1;
    #1;
    check({tag, ".dReq"}, 32'(dReq), 1);
    check({tag, ".dWe"}, 32'(dWe), 1);
    check({tag, ".dBe"}, 32'(dBe), 32'(exp_be));
    check({tag, ".dAddr"}, dAddr, exp_addr);
    check({tag, ".dWdata"}, dWdata, exp_wd);
    check({tag, ".stall"}, 32'(lsuStall), 0);
    tick();
    idle_inputs();
    #1;
    check({tag, ".dReq_after"}, 32'(dReq), 0);
    check({tag, ".stall_after"}, 32'(lsuStall), 0);
  endtask

  initial begin
    int stall_cnt;
    idle_inputs();
    rst = 1;
    #1;
    check_quiet("reset");
    tick();
    tick();
    check_quiet("reset_hold");
    check("reset.state", 32'(dut.state), 32'(IDLE));
    rst = 0;
    tick();

    // Stores: byte at lane 3, half at lane 2, forced-aligned half, word.
    store0("sb", F3_B, 32'h103, 32'h0000_00A5, 4'b1000, 32'h100, 32'hA5A5_A5A5);
    store0("sh", F3_H, 32'h006, 32'h1234_ABCD, 4'b1100, 32'h004, 32'hABCD_ABCD);
`ifndef LSU_MISALIGN_CHECK_EN
    store0("sh_odd", F3_H, 32'h007, 32'h1234_ABCD, 4'b1100, 32'h004, 32'hABCD_ABCD);
`endif
    store0("sw", F3_W, 32'h2C0, 32'hDEAD_BEEF, 4'b1111, 32'h2C0, 32'hDEAD_BEEF);

    // Byte loads with sign and zero extension.
    load0("lb",  F3_B,  32'h102, 4'b0100, 32'h100, 32'h0080_0000, 32'hFFFF_FF80);
    load0("lbu", F3_BU, 32'h102, 4'b0100, 32'h100, 32'h0080_0000, 32'h0000_0080);
    load0("lhu", F3_HU, 32'h012, 4'b1100, 32'h010, 32'h9ABC_0000, 32'h0000_9ABC);

    // LH with grant 3 cycles late and rvalid 2 cycles after grant; stallM
    // toggles while waiting for grant and must not disturb the bus.
    memReadM = 1; funct3M = F3_H; addrM = 32'h22;
    stall_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      dGnt    = (c == 3);
      dRvalid = (c == 5);
      dRdata  = (c == 5) ? 32'h8001_1234 : 32'h0;
      stallM  = (c == 1);
      #1;
      if (lsuStall) stall_cnt++;
      if (c <= 3) begin
        check($sformatf("lh.dReq%0d", c), 32'(dReq), 1);
        check($sformatf("lh.dAddr%0d", c), dAddr, 32'h20);
        check($sformatf("lh.dBe%0d", c), 32'(dBe), 32'b1100);
        check($sformatf("lh.dWe%0d", c), 32'(dWe), 0);
      end else begin
        check($sformatf("lh.dReq%0d", c), 32'(dReq), 0);
      end
      if (c == 5) check("lh.rd", readDataM, 32'hFFFF_8001);
      tick();
    end
    check("lh.stall_cycles", 32'(stall_cnt), 5);
    idle_inputs();
    #1;

    // LW completes while MEM is held for 3 cycles: data held, no re-issue.
    memReadM = 1; funct3M = F3_W; addrM = 32'h40; dGnt = 1; stallM = 1;
    #1;
    check("lw_hold.stall0", 32'(lsuStall), 1);
    tick();
    dGnt = 0; dRvalid = 1; dRdata = 32'h1234_5678;
    #1;
    check("lw_hold.rd1", readDataM, 32'h1234_5678);
    check("lw_hold.stall1", 32'(lsuStall), 0);
    tick();
    dRvalid = 0; dRdata = 32'h0;
    for (int c = 2; c < 5; c++) begin
      stallM = (c < 4);
      #1;
      check($sformatf("lw_hold.state%0d", c), 32'(dut.state), 32'(HOLD));
      check($sformatf("lw_hold.rd%0d", c), readDataM, 32'h1234_5678);
      check($sformatf("lw_hold.dReq%0d", c), 32'(dReq), 0);
      check($sformatf("lw_hold.stall%0d", c), 32'(lsuStall), 0);
      tick();
    end
    idle_inputs();
    #1;
    check("lw_hold.state_end", 32'(dut.state), 32'(IDLE));
    check("lw_hold.rd_end", readDataM, 0);
    tick();

    // Store with one grant wait cycle.
    memWriteM = 1; funct3M = F3_W; addrM = 32'h80; writeDataM = 32'h0BAD_F00D; dGnt = 0;
    #1;
    check("sw_wait.stall0", 32'(lsuStall), 1);
    tick();
    dGnt = 1;
    #1;
    check("sw_wait.dReq1", 32'(dReq), 1);
    check("sw_wait.dWdata1", dWdata, 32'h0BAD_F00D);
    check("sw_wait.stall1", 32'(lsuStall), 0);
    tick();
    idle_inputs();
    #1;
    check("sw_wait.dReq2", 32'(dReq), 0);

    // Misaligned word load.
`ifdef LSU_MISALIGN_CHECK_EN
    memReadM = 1; funct3M = F3_W; addrM = 32'h102; dGnt = 1;
    #1;
    check("lw_mis.mis", 32'(misalignM), 1);
    check("lw_mis.dReq", 32'(dReq), 0);
    check("lw_mis.stall", 32'(lsuStall), 0);
    check("lw_mis.rd", readDataM, 0);
    tick();
    idle_inputs();
    #1;
`else
    load0("lw_mis", F3_W, 32'h102, 4'b1111, 32'h100, 32'hCAFE_F00D, 32'hCAFE_F00D);
`endif

    // Reset while waiting for the response.
    memReadM = 1; funct3M = F3_W; addrM = 32'h300; dGnt = 1;
    tick();
    dGnt = 0;
    #1;
    check("rst_rsp.state", 32'(dut.state), 32'(WAIT_RSP));
    check("rst_rsp.stall", 32'(lsuStall), 1);
    rst = 1;
    idle_inputs();
    #1;
    check_quiet("rst_rsp.async");
    tick();
    check_quiet("rst_rsp.edge");
    check("rst_rsp.state_idle", 32'(dut.state), 32'(IDLE));
    rst = 0;
    tick();
    store0("sw_after_rst", F3_W, 32'h200, 32'h5566_7788, 4'b1111, 32'h200, 32'h5566_7788);

    tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
